// File: rtl/row_feeder_pkg.sv
// Shared types and helpers for the row package feeder.
package row_feeder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    WAIT_REQ,
    WAIT_FIN
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/package_assembler.sv
// Staging register for one NI-word package pair: slot index, read pipeline
// tracking, zero-pad insertion and MSB-first shift-in.
module package_assembler
  import row_feeder_pkg::*;
#(
  parameter int unsigned NI = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch,
  input  logic                 pad,
  input  logic [WORD_W-1:0]    a_data,
  input  logic [WORD_W-1:0]    b_data,
  output logic                 issue_c,
  output logic                 last_issued_c,
  output logic [WORD_W*NI-1:0] stage_a_next_c,
  output logic [WORD_W*NI-1:0] stage_b_next_c
);

  localparam int unsigned KW = $clog2(NI + 1);
  localparam int unsigned PW = WORD_W * NI;

  logic [KW-1:0] k;
  logic          vld1, pad1, last1;
  logic          vld2, pad2;
  logic [PW-1:0] stage_a, stage_b;

  assign issue_c       = fetch && (k != KW'(NI));
  assign last_issued_c = vld1 && last1;

  // Stage 1 tracks the registered read strobe, stage 2 the cycle its data is valid.
  always_comb begin
    stage_a_next_c = stage_a;
    stage_b_next_c = stage_b;
    if (vld2) begin
      stage_a_next_c = {stage_a[PW-WORD_W-1:0], pad2 ? WORD_W'(0) : a_data};
      stage_b_next_c = {stage_b[PW-WORD_W-1:0], pad2 ? WORD_W'(0) : b_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      vld1    <= 1'b0;
      pad1    <= 1'b0;
      last1   <= 1'b0;
      vld2    <= 1'b0;
      pad2    <= 1'b0;
      stage_a <= '0;
      stage_b <= '0;
    end else begin
      if (!fetch) k <= '0;
      else if (issue_c) k <= k + KW'(1);
      vld1    <= issue_c;
      pad1    <= pad;
      last1   <= issue_c && (k == KW'(NI - 1));
      vld2    <= vld1;
      pad2    <= pad1;
      stage_a <= stage_a_next_c;
      stage_b <= stage_b_next_c;
    end
  end

endmodule

// File: rtl/row_package_feeder.sv
// Feeds two NOE-element fp32 rows to the dot-product engine as NI-word packages.
// Define ROW_FEEDER_PREFETCH_EN to fetch the next package while the engine works.
module row_package_feeder
  import row_feeder_pkg::*;
#(
  parameter int unsigned NOE = 10,
  parameter int unsigned NI  = 8,
  parameter int unsigned AW  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [WORD_W-1:0]    mem_a_data,
  input  logic [WORD_W-1:0]    mem_b_data,
  output logic [WORD_W*NI-1:0] first_row_output,
  output logic [WORD_W*NI-1:0] second_row_output,
  output logic                 read_now,
  output logic [31:0]          no_of_multiples,
  input  logic                 prepare_new_input,
  input  logic                 finish,
  input  logic [WORD_W-1:0]    dot_product_in,
  output logic [WORD_W-1:0]    result,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NPKG = ceil_div(NOE, NI);
  localparam int unsigned EW   = $clog2(NPKG * NI + 1);
  localparam int unsigned PCW  = (NPKG > 1) ? $clog2(NPKG) : 1;
  localparam int unsigned PW   = WORD_W * NI;

  state_t        state, state_next;
  logic [PCW-1:0] pkg, pkg_next;
  logic [EW-1:0] elem, elem_next;
  logic [AW-1:0] base, base_next;
  logic          staged, staged_next;
  logic          pending, pending_next;

  logic              rd_en_next;
  logic [AW-1:0]     addr_next;
  logic [PW-1:0]     first_next, second_next;
  logic              read_now_next, done_next;
  logic [WORD_W-1:0] result_next;

  logic          issue_c, last_issued_c, pad_c, last_pkg_c;
  logic [PW-1:0] stage_a_next_c, stage_b_next_c;

  assign pad_c           = (elem >= EW'(NOE));
  assign last_pkg_c      = (pkg == PCW'(NPKG - 1));
  assign no_of_multiples = 32'(NPKG);

  package_assembler #(.NI(NI)) u_asm (
    .clk            (clk),
    .reset          (reset),
    .fetch          (state == FETCH),
    .pad            (pad_c),
    .a_data         (mem_a_data),
    .b_data         (mem_b_data),
    .issue_c        (issue_c),
    .last_issued_c  (last_issued_c),
    .stage_a_next_c (stage_a_next_c),
    .stage_b_next_c (stage_b_next_c)
  );

  always_comb begin
    state_next    = state;
    pkg_next      = pkg;
    elem_next     = elem;
    base_next     = base;
    staged_next   = staged;
    pending_next  = pending;
    rd_en_next    = 1'b0;
    addr_next     = mem_addr;
    first_next    = first_row_output;
    second_next   = second_row_output;
    read_now_next = 1'b0;
    result_next   = result;
    done_next     = 1'b0;

    // One slot per cycle; padded slots advance the element count without a read.
    if (issue_c) begin
      elem_next  = elem + EW'(1);
      rd_en_next = !pad_c;
      if (!pad_c) addr_next = base + AW'(elem);
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = FETCH;
          pkg_next     = '0;
          elem_next    = '0;
          base_next    = base_addr;
          staged_next  = 1'b0;
          pending_next = 1'b0;
        end
      end
      FETCH: begin
`ifdef ROW_FEEDER_PREFETCH_EN
        if (prepare_new_input) pending_next = 1'b1;
        if (last_issued_c) begin
          pending_next = 1'b0;
          if ((pkg == '0) || pending || prepare_new_input) begin
            state_next = PRESENT;
          end else begin
            state_next  = WAIT_REQ;
            staged_next = 1'b1;
          end
        end
`else
        if (last_issued_c) state_next = PRESENT;
`endif
      end
      PRESENT: begin
        // The last slot's data is on the bus now, so copy the post-capture value.
        first_next    = stage_a_next_c;
        second_next   = stage_b_next_c;
        read_now_next = 1'b1;
        staged_next   = 1'b0;
`ifdef ROW_FEEDER_PREFETCH_EN
        if (!last_pkg_c) begin
          state_next = FETCH;
          pkg_next   = pkg + PCW'(1);
        end else begin
          state_next = WAIT_REQ;
        end
`else
        state_next = WAIT_REQ;
`endif
      end
      WAIT_REQ: begin
        if (prepare_new_input) begin
          if (staged) begin
            state_next = PRESENT;
          end else if (!last_pkg_c) begin
            state_next = FETCH;
            pkg_next   = pkg + PCW'(1);
          end else begin
            state_next = WAIT_FIN;
          end
        end
      end
      WAIT_FIN: begin
        if (finish) begin
          result_next = dot_product_in;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pkg               <= '0;
      elem              <= '0;
      base              <= '0;
      staged            <= 1'b0;
      pending           <= 1'b0;
      mem_rd_en         <= 1'b0;
      mem_addr          <= '0;
      first_row_output  <= '0;
      second_row_output <= '0;
      read_now          <= 1'b0;
      result            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= state_next;
      pkg               <= pkg_next;
      elem              <= elem_next;
      base              <= base_next;
      staged            <= staged_next;
      pending           <= pending_next;
      mem_rd_en         <= rd_en_next;
      mem_addr          <= addr_next;
      first_row_output  <= first_next;
      second_row_output <= second_next;
      read_now          <= read_now_next;
      result            <= result_next;
      busy              <= (state_next != IDLE);
      done              <= done_next;
    end
  end

endmodule

// File: tb/tb_row_package_feeder.sv
// Directed bench: a padded-row feeder (NOE=10) and an exact-fit feeder (NOE=16).
module tb_row_package_feeder;

  localparam int unsigned NI = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned PW = 32 * NI;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] fa [10];

  logic          start0, prep0, fin0, rd0, rn0, busy0, done0;
  logic [AW-1:0] base0, addr0;
  logic [31:0]   qa0, qb0, dot0, res0, nom0;
  logic [PW-1:0] first0, second0;
  logic [AW-1:0] reads0 [$];

  logic          start1, prep1, fin1, rd1, rn1, busy1, done1;
  logic [AW-1:0] base1, addr1;
  logic [31:0]   qa1, qb1, dot1, res1, nom1;
  logic [PW-1:0] first1, second1;
  logic [AW-1:0] reads1 [$];

  row_package_feeder #(.NOE(10), .NI(NI), .AW(AW)) u0 (
    .clk(clk), .reset(reset), .start(start0), .base_addr(base0),
    .mem_rd_en(rd0), .mem_addr(addr0), .mem_a_data(qa0), .mem_b_data(qb0),
    .first_row_output(first0), .second_row_output(second0), .read_now(rn0),
    .no_of_multiples(nom0), .prepare_new_input(prep0), .finish(fin0),
    .dot_product_in(dot0), .result(res0), .busy(busy0), .done(done0)
  );

  row_package_feeder #(.NOE(16), .NI(NI), .AW(AW)) u1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base1),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_a_data(qa1), .mem_b_data(qb1),
    .first_row_output(first1), .second_row_output(second1), .read_now(rn1),
    .no_of_multiples(nom1), .prepare_new_input(prep1), .finish(fin1),
    .dot_product_in(dot1), .result(res1), .busy(busy1), .done(done1)
  );

  // Synchronous-read memories shared by both feeders, plus address logs.
  always @(posedge clk) begin
    if (rd0) begin
      qa0 <= mem_a[addr0];
      qb0 <= mem_b[addr0];
      reads0.push_back(addr0);
    end
    if (rd1) begin
      qa1 <= mem_a[addr1];
      qb1 <= mem_b[addr1];
      reads1.push_back(addr1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] exp_pat(input logic [7:0] tag, input int first, input int nvalid);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < NI; k++)
      if (k < nvalid) v[32*(NI-k)-1 -: 32] = {tag, 14'd0, 10'((first + k) % 1024)};
    return v;
  endfunction

  function automatic logic [PW-1:0] exp_flt(input int first, input int nvalid, input logic is_b);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < NI; k++)
      if (k < nvalid) v[32*(NI-k)-1 -: 32] = is_b ? 32'h4000_0000 : fa[first + k];
    return v;
  endfunction

  task automatic wait_rn0(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rn0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rn1(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rn1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Raise a request sampled NI+3 edges after the read_now cycle rn_at.
  task automatic req0_after(input int rn_at, output int r);
    for (int i = 0; i < 40 && cyc < rn_at + NI + 2; i++) tick();
    prep0 = 1'b1;
    tick();
    r = cyc;
    prep0 = 1'b0;
  endtask

  task automatic req1_after(input int rn_at, output int r);
    for (int i = 0; i < 40 && cyc < rn_at + NI + 2; i++) tick();
    prep1 = 1'b1;
    tick();
    r = cyc;
    prep1 = 1'b0;
  endtask

  function automatic int next_rn_exp(input int r);
`ifdef ROW_FEEDER_PREFETCH_EN
    return r + 1;
`else
    return r + NI + 2;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    total++; if ({rd0, addr0} !== '0) begin bad++; $display("FAIL reset_mem got rd=%0b addr=%0d want 0 0", rd0, addr0); end
    total++; if ({first0, second0} !== '0) begin bad++; $display("FAIL reset_pkgs got %h %h want 0", first0, second0); end
    total++; if ({rn0, busy0, done0} !== 3'b000) begin bad++; $display("FAIL reset_flags got rn=%0b busy=%0b done=%0b want 000", rn0, busy0, done0); end
    total++; if (res0 !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", res0); end
    total++; if (nom0 !== 32'd2) begin bad++; $display("FAIL multiples_10 got %0d want 2", nom0); end
    total++; if (nom1 !== 32'd2) begin bad++; $display("FAIL multiples_16 got %0d want 2", nom1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_padded_rows();
    int t, at, r;
    int errs;
    reads0.delete();
    base0 = 10'd100;
    start0 = 1'b1;
    tick();
    t = cyc;
    start0 = 1'b0;
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL busy_after_start got %0b want 1", busy0); end
    tick(); tick();
    start0 = 1'b1;
    base0 = 10'd500;
    tick();
    start0 = 1'b0;
    base0 = 10'd100;
    wait_rn0(at);
    total++; if (at !== t + 10) begin bad++; $display("FAIL pad_rn0_cycle got %0d want %0d", at, t + 10); end
    total++; if (first0 !== exp_flt(0, 8, 1'b0)) begin bad++; $display("FAIL pad_pkg0_a got %h want %h", first0, exp_flt(0, 8, 1'b0)); end
    total++; if (second0 !== exp_flt(0, 8, 1'b1)) begin bad++; $display("FAIL pad_pkg0_b got %h want %h", second0, exp_flt(0, 8, 1'b1)); end
    tick();
    total++; if (rn0 !== 1'b0) begin bad++; $display("FAIL rn_one_cycle got %0b want 0", rn0); end
    total++; if (first0 !== exp_flt(0, 8, 1'b0)) begin bad++; $display("FAIL pkg_hold got %h want %h", first0, exp_flt(0, 8, 1'b0)); end
    req0_after(at, r);
    wait_rn0(at);
    total++; if (at !== next_rn_exp(r)) begin bad++; $display("FAIL pad_rn1_cycle got %0d want %0d", at, next_rn_exp(r)); end
    total++; if (first0 !== exp_flt(8, 2, 1'b0)) begin bad++; $display("FAIL pad_pkg1_a got %h want %h", first0, exp_flt(8, 2, 1'b0)); end
    total++; if (second0 !== exp_flt(8, 2, 1'b1)) begin bad++; $display("FAIL pad_pkg1_b got %h want %h", second0, exp_flt(8, 2, 1'b1)); end
    errs = 0;
    foreach (reads0[i]) if (reads0[i] !== AW'(100 + i)) errs++;
    total++; if (reads0.size() !== 10 || errs !== 0) begin bad++; $display("FAIL pad_reads got n=%0d bad_addr=%0d want n=10 bad_addr=0", reads0.size(), errs); end
    prep0 = 1'b1;
    tick();
    prep0 = 1'b0;
    tick();
    total++; if ({busy0, done0} !== 2'b10) begin bad++; $display("FAIL wait_fin_flags got busy=%0b done=%0b want 1 0", busy0, done0); end
    fin0 = 1'b1;
    dot0 = 32'h42C8_0000;
    tick();
    fin0 = 1'b0;
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL done_pulse got %0b want 1", done0); end
    total++; if (res0 !== 32'h42C8_0000) begin bad++; $display("FAIL result got %h want 42c80000", res0); end
    tick();
    total++; if ({busy0, done0} !== 2'b00) begin bad++; $display("FAIL after_done got busy=%0b done=%0b want 0 0", busy0, done0); end
  endtask

  task automatic test_full_rows();
    int t, at, r;
    int errs;
    reads1.delete();
    base1 = 10'd200;
    start1 = 1'b1;
    tick();
    t = cyc;
    start1 = 1'b0;
    wait_rn1(at);
    total++; if (at !== t + 10) begin bad++; $display("FAIL full_rn0_cycle got %0d want %0d", at, t + 10); end
    total++; if (first1 !== exp_pat(8'hA5, 200, 8)) begin bad++; $display("FAIL full_pkg0_a got %h want %h", first1, exp_pat(8'hA5, 200, 8)); end
    req1_after(at, r);
    wait_rn1(at);
    total++; if (at !== next_rn_exp(r)) begin bad++; $display("FAIL full_rn1_cycle got %0d want %0d", at, next_rn_exp(r)); end
    total++; if (first1 !== exp_pat(8'hA5, 208, 8)) begin bad++; $display("FAIL full_pkg1_a got %h want %h", first1, exp_pat(8'hA5, 208, 8)); end
    total++; if (second1 !== exp_pat(8'hB6, 208, 8)) begin bad++; $display("FAIL full_pkg1_b got %h want %h", second1, exp_pat(8'hB6, 208, 8)); end
    errs = 0;
    foreach (reads1[i]) if (reads1[i] !== AW'(200 + i)) errs++;
    total++; if (reads1.size() !== 16 || errs !== 0) begin bad++; $display("FAIL full_reads got n=%0d bad_addr=%0d want n=16 bad_addr=0", reads1.size(), errs); end
    // Request and finish in the same cycle on the last package.
    prep1 = 1'b1;
    fin1 = 1'b1;
    dot1 = 32'h3F00_0000;
    tick();
    prep1 = 1'b0;
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL joint_early_done got %0b want 0", done1); end
    tick();
    fin1 = 1'b0;
    total++; if ({done1, res1} !== {1'b1, 32'h3F00_0000}) begin bad++; $display("FAIL joint_done got done=%0b res=%h want 1 3f000000", done1, res1); end
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL joint_idle got busy=%0b want 0", busy1); end
  endtask

  task automatic test_reset_mid();
    int t, at, r, seen;
    base0 = 10'd100;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_rn0(at);
    req0_after(at, r);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({rd0, addr0, rn0, busy0, done0} !== '0) begin bad++; $display("FAIL midreset_ctl got rd=%0b addr=%0d rn=%0b busy=%0b done=%0b want all 0", rd0, addr0, rn0, busy0, done0); end
    total++; if ({first0, second0, res0} !== '0) begin bad++; $display("FAIL midreset_data got res=%h pkgs_nonzero=%0b want 0", res0, |{first0, second0}); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rn0 || done0 || rd0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_quiet got %0d active cycles want 0", seen); end
    reads0.delete();
    start0 = 1'b1;
    tick();
    t = cyc;
    start0 = 1'b0;
    wait_rn0(at);
    total++; if (at !== t + 10) begin bad++; $display("FAIL restart_rn_cycle got %0d want %0d", at, t + 10); end
    total++; if (first0 !== exp_flt(0, 8, 1'b0)) begin bad++; $display("FAIL restart_pkg0 got %h want %h", first0, exp_flt(0, 8, 1'b0)); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int t, at, r;
    int errs;
    reads0.delete();
    base0 = 10'd1021;
    start0 = 1'b1;
    tick();
    t = cyc;
    start0 = 1'b0;
    wait_rn0(at);
    total++; if (at !== t + 10) begin bad++; $display("FAIL wrap_rn0_cycle got %0d want %0d", at, t + 10); end
    total++; if (first0 !== exp_pat(8'hA5, 1021, 8)) begin bad++; $display("FAIL wrap_pkg0_a got %h want %h", first0, exp_pat(8'hA5, 1021, 8)); end
    req0_after(at, r);
    wait_rn0(at);
    total++; if (second0 !== exp_pat(8'hB6, 1029, 2)) begin bad++; $display("FAIL wrap_pkg1_b got %h want %h", second0, exp_pat(8'hB6, 1029, 2)); end
    errs = 0;
    foreach (reads0[i]) if (reads0[i] !== AW'((1021 + i) % 1024)) errs++;
    total++; if (reads0.size() !== 10 || errs !== 0) begin bad++; $display("FAIL wrap_reads got n=%0d bad_addr=%0d want n=10 bad_addr=0", reads0.size(), errs); end
    prep0 = 1'b1;
    tick();
    prep0 = 1'b0;
    fin0 = 1'b1;
    dot0 = 32'h1234_5678;
    tick();
    fin0 = 1'b0;
    total++; if ({done0, res0} !== {1'b1, 32'h1234_5678}) begin bad++; $display("FAIL wrap_done got done=%0b res=%h want 1 12345678", done0, res0); end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start0 = 1'b0; prep0 = 1'b0; fin0 = 1'b0; base0 = '0; dot0 = '0;
    start1 = 1'b0; prep1 = 1'b0; fin1 = 1'b0; base1 = '0; dot1 = '0;
    qa0 = '0; qb0 = '0; qa1 = '0; qb1 = '0;
    fa = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
           32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000};
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = {8'hA5, 14'd0, 10'(i)};
      mem_b[i] = {8'hB6, 14'd0, 10'(i)};
    end
    for (int i = 0; i < 10; i++) begin
      mem_a[100 + i] = fa[i];
      mem_b[100 + i] = 32'h4000_0000;
    end
    test_reset();
    test_padded_rows();
    test_full_rows();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_package_feeder.md
# row_package_feeder

Streaming source that supplies two NOE-element fp32 row vectors to the NI-lane dot-product engine. It fetches the rows from two word-addressed memories and assembles them into NI-word packages, zero-padding the tail package. It presents each package with a one-cycle `read_now` strobe and advances when the engine requests its next input. It then waits for the engine's `finish` and captures the dot-product result for the controller above.

## Interface
- `NOE`, 10, elements per row; must be ≥1.
- `NI`, 8, words per package (lanes); must be 8 or 16.
- `AW`, 10, memory address width.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a transfer of one row pair; ignored unless idle.
- `base_addr` in AW: address of element 0 in both memories; sampled with `start`.
- `mem_rd_en` out 1: read enable, common to both memories.
- `mem_addr` out AW: read address, common to both memories.
- `mem_a_data` in 32: first-row memory read data; valid 1 cycle after `mem_rd_en`.
- `mem_b_data` in 32: second-row memory read data; valid 1 cycle after `mem_rd_en`.
- `first_row_output` out 32*NI: first-row package presented to the engine.
- `second_row_output` out 32*NI: second-row package presented to the engine.
- `read_now` out 1: one-cycle strobe marking that a new package is on the outputs.
- `no_of_multiples` out 32: constant ceil(NOE/NI).
- `prepare_new_input` in 1: engine request for the next package.
- `finish` in 1: engine result-ready flag (level).
- `dot_product_in` in 32: engine result.
- `result` out 32: captured dot product.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when `result` is updated.

## Operation
- Package p, word k carries element e = p*NI + k. The word sits at bits [32*(NI-k)-1 -: 32], so word 0 is MSB-most; the engine consumes the upper half first.
- Elements with e ≥ NOE are forced to 32'h0 and not read. `mem_rd_en` stays low in those cycles.
- FSM states:
  - IDLE: on `start`, go to FETCH with p=0, k=0.
  - FETCH: issue one read per cycle at base+e for k=0..NI-1 (padded slots still take one cycle each). Returned data fills a staging register. After the last capture, go to PRESENT.
  - PRESENT: copy staging to the output registers, pulse `read_now`, and go to WAIT_REQ.
  - WAIT_REQ: on `prepare_new_input` with p < ceil(NOE/NI)-1, increment p and go to FETCH. On `prepare_new_input` with the last package presented, go to WAIT_FIN. Requests seen in other states are dropped.
  - WAIT_FIN: on `finish` high, set `result` to `dot_product_in`, pulse `done`, and go to IDLE.
- `busy` is high in every state except IDLE.
- Output packages hold stable from `read_now` until the next PRESENT. The engine may sample either half in any later cycle.
- Address arithmetic is modulo 2^AW, so wrap-around is silent.
- `start` while busy is ignored. `base_addr` is latched only in IDLE.

## Timing
- Reset values:
  - `mem_rd_en`=0, `mem_addr`=0
  - both packages=0, `read_now`=0
  - `result`=0, `busy`=0, `done`=0
  - FSM in IDLE, p=0, k=0, staging=0
- Reset mid-transfer aborts immediately. No `read_now` or `done` follows it.
- `start` sampled at edge T: first `mem_rd_en` at cycle T+1. `read_now` is high during cycle T+NI+2.
- Request to next `read_now` without prefetch: `prepare_new_input` at edge R gives `read_now` at R+NI+2.
- `done` is asserted the cycle after `finish` is sampled high in WAIT_FIN.
- If `prepare_new_input` and `finish` arrive together in WAIT_REQ on the last package, go to WAIT_FIN. `finish` is re-evaluated there.

## Configuration
- `ROW_FEEDER_PREFETCH_EN` defined:
  - After PRESENT, fetching of package p+1 into staging starts immediately, if one exists.
  - A request arriving once staging is full produces `read_now` one cycle later.
  - A request arriving during the prefetch is held and served when staging fills.
  - Memory port use is otherwise identical.
- `ROW_FEEDER_PREFETCH_EN` undefined: fetching starts only on request, as described in Operation.

## Structure
- Shared package `row_feeder_pkg`:
  - FSM state enum: IDLE, FETCH, PRESENT, WAIT_REQ, WAIT_FIN.
  - `WORD_W`=32.
  - Function `ceil_div(NOE,NI)` used for `no_of_multiples`.
- One sub-module, `package_assembler`: holds the staging register, the word index k, zero-pad insertion and the NI-word shift-in.
- The FSM and address counter live in the top module.

## Test plan
- NOE=10, NI=8; A[i]=i+1, B[i]=2.0, `start` → `no_of_multiples`=2; package 0 = A[0..7]; package 1 = A[8], A[9], then six zeros. No reads are issued for e ≥ 10.
- NOE=16, NI=8 → exactly 2 packages and no zero words. `read_now` at T+10; `mem_addr` runs base..base+15.
- Feed `finish` with `dot_product_in`=32'h42C80000 → `result`=32'h42C80000 and `done` high for one cycle; then IDLE, `busy`=0.
- Assert `reset` during FETCH of package 1 → all outputs return to their reset values, and no `read_now` or `done` follows. A new `start` restarts at package 0.
- `base_addr`=2^AW−3, NOE=10 → addresses wrap to 0 after 2^AW−1.
- With `ROW_FEEDER_PREFETCH_EN`, request NI+3 cycles after `read_now` → next `read_now` exactly 1 cycle after the request.
